// File: rtl/gpio_control_pkg.sv
// Shared constants for the gpio_control_ip register block.
// Register byte offsets (word aligned) and the data path width.
package gpio_control_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] OFF_DATA = 5'h00;
    localparam logic [4:0] OFF_DIR  = 5'h04;
    localparam logic [4:0] OFF_READ = 5'h08;
    localparam logic [4:0] OFF_SET  = 5'h0C;
    localparam logic [4:0] OFF_CLR  = 5'h10;
    localparam logic [4:0] OFF_TGL  = 5'h14;

    // Word-aligned offset from a byte address; addr[1:0] is ignored.
    function automatic logic [4:0] word_off(input logic [2:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop input synchronizer, compiled only when GPIO_INPUT_SYNC_EN is defined.
// Both stages clear on synchronous reset.
`ifdef GPIO_INPUT_SYNC_EN
module gpio_in_sync
    import gpio_control_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule
`endif

// File: rtl/gpio_control_ip.sv
// Memory-mapped 32-bit GPIO controller: data, direction, pin readback, set/clr/toggle.
// Define GPIO_INPUT_SYNC_EN to pass gpio_in through a 2-flop synchronizer.
module gpio_control_ip
    import gpio_control_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_DATA = 32'h0000_0000,
    parameter logic [DATA_W-1:0] RESET_DIR  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic              chip_select,
    input  logic [DATA_W-1:0] gpio_in,
    output logic [DATA_W-1:0] gpio_out
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] dir_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] dir_d;
    logic [DATA_W-1:0] pins;
    logic [DATA_W-1:0] read_val;
    logic [4:0]        off;
    logic              wr;
    logic              rd;
    logic              unused_addr;

    assign off         = word_off(addr[4:2]);
    assign wr          = chip_select & write_enable;
    assign rd          = chip_select & read_enable;
    assign unused_addr = ^{addr[31:5], addr[1:0]};

`ifdef GPIO_INPUT_SYNC_EN
    gpio_in_sync #(
        .WIDTH(DATA_W)
    ) u_in_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (gpio_in),
        .dout (pins)
    );
`else
    assign pins = gpio_in;
`endif

    assign gpio_out = data_q & dir_q;

    always_comb begin
        read_val = '0;
        case (off)
            OFF_DATA: read_val = data_q;
            OFF_DIR:  read_val = dir_q;
            OFF_READ: read_val = (data_q & dir_q) | (pins & ~dir_q);
            default:  read_val = '0;
        endcase
    end

    // Read-only and unmapped offsets fall through and leave state untouched.
    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        if (wr) begin
            case (off)
                OFF_DATA: data_d = write_data;
                OFF_DIR:  dir_d  = write_data;
                OFF_SET:  data_d = data_q | write_data;
                OFF_CLR:  data_d = data_q & ~write_data;
                OFF_TGL:  data_d = data_q ^ write_data;
                default:  data_d = data_q;
            endcase
        end
    end

    // read_val is taken from pre-edge state, so a same-cycle write reads old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= RESET_DATA;
            dir_q     <= RESET_DIR;
            read_data <= '0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            if (rd) begin
                read_data <= read_val;
            end
        end
    end

endmodule

// File: tb/tb_gpio_control_ip.sv
// Randomized self-checking bench for gpio_control_ip against a register-level model.
// Honors GPIO_INPUT_SYNC_EN by delaying the modelled pin samples two clocks.
module tb_gpio_control_ip;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic        chip_select = 1'b0;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_data = '0;
    logic [31:0] m_dir  = '0;
    logic [31:0] m_rd   = '0;
    logic [31:0] m_s1   = '0;
    logic [31:0] m_s2   = '0;

    always #5 clk = ~clk;

    gpio_control_ip dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .write_data   (write_data),
        .read_data    (read_data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .chip_select  (chip_select),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_pins();
`ifdef GPIO_INPUT_SYNC_EN
        return m_s2;
`else
        return gpio_in;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[4:2])
            3'd0:    return m_data;
            3'd1:    return m_dir;
            3'd2:    return (m_data & m_dir) | (m_pins() & ~m_dir);
            default: return 32'h0;
        endcase
    endfunction

    // One clock: advance the model from the current inputs, then compare.
    task automatic step();
        logic [31:0] nd;
        logic [31:0] ndir;
        logic [31:0] nrd;
        nd   = m_data;
        ndir = m_dir;
        nrd  = m_rd;
        if (rst) begin
            nd   = 32'h0;
            ndir = 32'h0;
            nrd  = 32'h0;
        end else begin
            if (chip_select && read_enable) nrd = m_read(addr);
            if (chip_select && write_enable) begin
                case (addr[4:2])
                    3'd0: nd   = write_data;
                    3'd1: ndir = write_data;
                    3'd3: nd   = m_data | write_data;
                    3'd4: nd   = m_data & ~write_data;
                    3'd5: nd   = m_data ^ write_data;
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        m_data = nd;
        m_dir  = ndir;
        m_rd   = nrd;
        if (rst) begin
            m_s2 = 32'h0;
            m_s1 = 32'h0;
        end else begin
            m_s2 = m_s1;
            m_s1 = gpio_in;
        end
        chk("read_data", read_data, m_rd);
        chk("gpio_out", gpio_out, m_data & m_dir);
    endtask

    task automatic bus(input logic cs, input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d);
        chip_select  = cs;
        write_enable = we;
        read_enable  = re;
        addr         = a;
        write_data   = d;
        step();
        chip_select  = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        bus(1'b1, 1'b0, 1'b1, a, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        rd(32'h00); chk("rst_data", read_data, 32'h0);
        rd(32'h04); chk("rst_dir", read_data, 32'h0);
        rd(32'h08); chk("rst_read", read_data, 32'h0);
        chk("rst_out", gpio_out, 32'h0);

        wr(32'h04, 32'hFFFF_FFFF);
        wr(32'h00, 32'h1234_5678);
        rd(32'h04); chk("dir_all", read_data, 32'hFFFF_FFFF);
        rd(32'h00); chk("data_all", read_data, 32'h1234_5678);
        chk("out_all", gpio_out, 32'h1234_5678);
        rd(32'h08); chk("read_all", read_data, 32'h1234_5678);

        gpio_in = 32'h0000_DEAD;
        wr(32'h04, 32'hFFFF_0000);
        wr(32'h00, 32'hABCD_EF00);
        rd(32'h08); chk("read_mix", read_data, 32'hABCD_DEAD);
        chk("out_mix", gpio_out, 32'hABCD_0000);
        rd(32'h00); chk("data_mix", read_data, 32'hABCD_EF00);

        wr(32'h00, 32'h0000_FFFF);
        wr(32'h0C, 32'hF000_0000);
        wr(32'h10, 32'h0000_000F);
        wr(32'h14, 32'h0000_0101);
        rd(32'h00); chk("set_clr_tgl", read_data, 32'hF000_FEF1);

        bus(1'b0, 1'b1, 1'b1, 32'h00, 32'h0);
        chk("cs_low_rd", read_data, 32'hF000_FEF1);
        rd(32'h00); chk("cs_low_wr", read_data, 32'hF000_FEF1);
        wr(32'h08, 32'hFFFF_FFFF);
        rd(32'h00); chk("ro_wr_data", read_data, 32'hF000_FEF1);
        rd(32'h04); chk("ro_wr_dir", read_data, 32'hFFFF_0000);
        rd(32'h1C); chk("unmapped", read_data, 32'h0);
        rd(32'h0C); chk("wo_read", read_data, 32'h0);
        rd(32'hFFFF_FFE7); chk("addr_alias", read_data, 32'hFFFF_0000);

        bus(1'b1, 1'b1, 1'b1, 32'h00, 32'h0000_0055);
        chk("rw_old", read_data, 32'hF000_FEF1);
        rd(32'h00); chk("rw_new", read_data, 32'h0000_0055);
        step(); chk("hold", read_data, 32'h0000_0055);

        rst = 1'b1;
        wr(32'h04, 32'hFFFF_FFFF);
        chk("mid_rst_rd", read_data, 32'h0);
        rst = 1'b0;
        rd(32'h04); chk("mid_rst_dir", read_data, 32'h0);

        gpio_in = 32'hA5A5_0000;
        for (int i = 0; i < 4; i++) rd(32'h08);
        gpio_in = 32'h0F0F_1234;
        for (int i = 0; i < 4; i++) rd(32'h08);

        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            gpio_in = $urandom;
            bus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1,
                {$urandom_range(0, 255), 24'h0} | {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)},
                $urandom);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_control_ip.md
Name: gpio_control_ip

Overview:
- Memory-mapped 32-bit GPIO controller on the simple peripheral bus (addr / write_data / read_data / write_enable / read_enable / chip_select).
- Per-pin direction control, an output data register, and a combined pin-state read register.
- Drives gpio_out from output-configured pins; samples gpio_in for input-configured pins.
- Sits behind the system address decoder; the upper address bits are decoded externally into chip_select.

Parameters:
- RESET_DATA, 32'h0000_0000, reset value of GPIO_DATA.
- RESET_DIR, 32'h0000_0000, reset value of GPIO_DIR (1 = output); default is all pins input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  byte address; only addr[4:2] is decoded, addr[1:0] and addr[31:5] are ignored.
- write_data  input  32  write data.
- read_data  output  32  registered read data.
- write_enable  input  1  write strobe, qualified by chip_select.
- read_enable  input  1  read strobe, qualified by chip_select.
- chip_select  input  1  block select; with chip_select=0, no register or read_data change.
- gpio_in  input  32  external pin inputs.
- gpio_out  output  32  pin outputs.

Behaviour:
- Register map (word offsets):
  - 0x00 GPIO_DATA: RW.
  - 0x04 GPIO_DIR: RW; bit = 1 means output.
  - 0x08 GPIO_READ: RO; value = (GPIO_DATA & GPIO_DIR) | (gpio_in & ~GPIO_DIR).
  - 0x0C GPIO_SET: WO; GPIO_DATA |= write_data.
  - 0x10 GPIO_CLR: WO; GPIO_DATA &= ~write_data.
  - 0x14 GPIO_TGL: WO; GPIO_DATA ^= write_data.
  - 0x18, 0x1C: unmapped.
- Reset (rst=1 at a clk edge):
  - GPIO_DATA <= RESET_DATA; GPIO_DIR <= RESET_DIR; read_data <= 0.
  - Reset has priority over any simultaneous access and aborts any in-flight access.
- Write: at a clk edge with chip_select && write_enable, the addressed register updates. The new value is visible on gpio_out and on readback from the next cycle.
- Writes to GPIO_READ or unmapped offsets are ignored.
- gpio_out = GPIO_DATA & GPIO_DIR, computed combinationally from the registers. Input-configured pins drive 0.
- Read:
  - At a clk edge with chip_select && read_enable, read_data <= the addressed value; one-cycle latency.
  - Write-only and unmapped offsets read as 0.
  - read_data holds its last value when no read is active.
- Simultaneous read and write to the same offset: read_data returns the pre-write value; the write takes effect normally.
- gpio_in is sampled combinationally into the GPIO_READ value at the read edge; no synchronizer unless the optional feature is enabled.
- Direction change: GPIO_DATA is retained. Pins switched to output immediately drive the stored GPIO_DATA bits.

Optional Feature:
- Macro GPIO_INPUT_SYNC_EN.
- Defined: gpio_in passes through a 2-flop synchronizer (reset to 0) before use in GPIO_READ. Input changes become visible in GPIO_READ 2 cycles later.
- Undefined: gpio_in is used directly, with no added latency.

Decomposition:
- Package gpio_control_pkg:
  - Register offset constants: OFF_DATA=0x00, OFF_DIR=0x04, OFF_READ=0x08, OFF_SET=0x0C, OFF_CLR=0x10, OFF_TGL=0x14.
  - Data width constant 32.
- Sub-module gpio_in_sync: 2-flop synchronizer instantiated only under GPIO_INPUT_SYNC_EN. Everything else stays in the top module.

Test Plan:
- Reset: after rst, read 0x00, 0x04, 0x08 with gpio_in=0 -> all return 0x00000000; gpio_out=0.
- Write 0xFFFFFFFF to 0x04, then 0x12345678 to 0x00 -> DIR readback 0xFFFFFFFF; DATA readback 0x12345678; gpio_out=0x12345678; GPIO_READ=0x12345678.
- Write DIR=0xFFFF0000, DATA=0xABCDEF00, gpio_in=0x0000DEAD -> GPIO_READ=0xABCDDEAD; gpio_out=0xABCD0000; DATA readback 0xABCDEF00.
- Set/clear/toggle with DATA=0x0000FFFF: write 0xF0000000 to 0x0C, 0x0000000F to 0x10, 0x00000101 to 0x14 -> DATA=0xF000FEF1.
- Access gating:
  - chip_select=0 with write_enable=1 -> no register change.
  - Write to 0x08 -> ignored.
  - Read of 0x1C -> 0.
  - Simultaneous read+write of 0x00 -> read_data shows old value, next read shows new.
- Mid-operation reset: assert rst in the same cycle as a write of 0xFFFFFFFF to 0x04 -> DIR=RESET_DIR, read_data=0.
- With GPIO_INPUT_SYNC_EN: a gpio_in change is visible in GPIO_READ exactly 2 cycles later.
